mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single CPU-side port of l2cache between two requesters: the instruction-fetch path (I) and the load/store path (D).
- Sits between CPU-internal L1 logic and l2cache.
- Serialises transactions: one outstanding access at a time, held until the downstream ready.
- D normally wins; a starvation counter guarantees I forward progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced ahead (1..15)

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held until i_ready
- i_addr  in  AW  instruction address
- i_rdata  out  DW  instruction read data; valid when i_ready
- i_ready  out  1  one-cycle completion pulse to I
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data; valid when d_ready
- d_ready  out  1  one-cycle completion pulse to D
- l2_req  out  1  request to l2cache
- l2_we  out  1  write enable to l2cache
- l2_addr  out  AW  address to l2cache
- l2_wdata  out  DW  write data to l2cache
- l2_rdata  in  DW  read data from l2cache
- l2_ready  in  1  l2cache completion; one-cycle pulse

Behaviour:
- Reset (synchronous, RESET high at a rising CLOCK edge):
  - All outputs go to 0, state goes to IDLE, starve_cnt goes to 0.
  - An in-flight transaction is abandoned: l2_req drops on the next cycle and no ready pulse is issued.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, request sampled at the edge:
  - d_req && i_req && starve_cnt == STARVE_LIMIT: grant I.
  - d_req: grant D.
  - i_req: grant I.
  - Neither: stay in IDLE.
- Grant edge:
  - l2_addr, l2_we and l2_wdata are registered from the winner. l2_we is forced to 0 for I.
  - l2_req goes to 1 in the first BUSY cycle.
  - Grant-to-l2_req latency is 1 cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each D grant made while i_req is high.
  - Clears on any I grant.
  - Holds otherwise.
- BUSY_x:
  - l2_req and the address/data registers are held stable until l2_ready.
  - There is no timeout; l2cache stalls are unbounded.
- Completion:
  - On l2_ready in BUSY_x, l2_req goes to 0 and the state moves to RESP.
  - In the same edge, l2_rdata is captured into x_rdata; it is captured for D writes too, and the value is don't-care.
- RESP (one cycle):
  - The granted x_ready is 1 for exactly this cycle. The ungranted ready stays 0.
  - Requests are ignored in RESP. This prevents re-serving a requester that drops req only after seeing ready.
  - Next state is IDLE.
- x_rdata holds its last value until the next completion for that requester.
- Minimum transaction with a zero-wait l2cache (l2_ready in the first BUSY cycle): req sampled at edge 0, l2_req high in cycle 1, ready pulse in cycle 2, next grant at edge 3.
- Requesters must hold req, addr, we and wdata stable from assertion until ready. Changes before grant are allowed: the value sampled at the grant edge is used.
- l2_ready outside BUSY is ignored.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: D is granted.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, RESP=2'd3) and requester ID constants (REQ_I=1'b0, REQ_D=1'b1), for reuse by later multi-port arbiters.
- One natural sub-module, arb_prio_pick: combinational winner selection from d_req, i_req and the starve flag, plus the starve counter register.
- The FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
1. I-only read: i_req=1, i_addr=0x00000010, l2 returns 0x8C010004 after 3 wait cycles -> l2_req high for 4 cycles with l2_we=0 and l2_addr=0x10; i_ready pulses once; i_rdata=0x8C010004; d_ready stays 0.
2. D write: d_req=1, d_we=1, d_addr=0x00080000, d_wdata=0xDEADBEEF, zero-wait l2 -> l2_we=1, l2_addr=0x80000, l2_wdata=0xDEADBEEF; d_ready pulses in the cycle after l2_ready.
3. Simultaneous i_req and d_req from reset -> D granted first; I granted immediately after D's RESP; starve_cnt is 1 then 0.
4. Starvation, STARVE_LIMIT=4: d_req held high continuously (re-requesting after each ready) while i_req is held -> exactly 4 D grants, then the I grant, then D again.
5. RESET asserted mid-BUSY_D with l2_ready withheld -> next cycle l2_req=0, state IDLE, no d_ready pulse; a new I request afterwards completes normally.
6. Spurious l2_ready in IDLE with a requester dropping req right after its ready -> no ready pulse, no second transaction, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the l2cache port arbiter: state encoding, requester IDs
// and the starvation-counter helper, kept here so later multi-port arbiters can reuse them.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned StarveCntW = 4;

    // Saturating increment used by the starvation counter.
    function automatic logic [StarveCntW-1:0] sat_inc(
        input logic [StarveCntW-1:0] cnt,
        input logic [StarveCntW-1:0] limit
    );
        logic [StarveCntW-1:0] res;
        res = cnt;
        if (cnt < limit) begin
            res = cnt + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio_pick.sv
// Winner selection between I and D (D-first with a starvation override for I)
// together with the starvation counter that drives the override.
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pick_en_i,
    input  logic                  i_req_i,
    input  logic                  d_req_i,
    output logic                  grant_o,
    output logic                  winner_o,
    output logic [StarveCntW-1:0] starve_cnt_o
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
    logic                  starved;

    always_comb begin
        starved  = (starve_cnt_q == Limit);
        grant_o  = pick_en_i && (i_req_i || d_req_i);
        winner_o = REQ_I;
        if (d_req_i && !(i_req_i && starved)) begin
            winner_o = REQ_D;
        end
    end

    // Only D grants made while I is waiting count towards starvation.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_o) begin
            if (winner_o == REQ_I) begin
                starve_cnt_d = '0;
            end else if (i_req_i) begin
                starve_cnt_d = sat_inc(starve_cnt_q, Limit);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the instruction-fetch and load/store paths onto the single l2cache port,
// one outstanding access at a time, with a one-cycle ready pulse back to the winner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          l2_req,
    output logic          l2_we,
    output logic [AW-1:0] l2_addr,
    output logic [DW-1:0] l2_wdata,
    input  logic [DW-1:0] l2_rdata,
    input  logic          l2_ready
);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         i_rdata_q, i_rdata_d;
    logic [DW-1:0]         d_rdata_q, d_rdata_d;

    logic                  pick_en;
    logic                  grant;
    logic                  winner;
    logic [StarveCntW-1:0] starve_cnt;

    assign pick_en = (state_q == StIdle);

    arb_prio_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .pick_en_i    (pick_en),
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .grant_o      (grant),
        .winner_o     (winner),
        .starve_cnt_o (starve_cnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    owner_d = winner;
                    if (winner == REQ_D) begin
                        state_d = StBusyD;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = StBusyI;
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            StBusyI: begin
                if (l2_ready) begin
                    state_d   = StResp;
                    i_rdata_d = l2_rdata;
                end
            end
            StBusyD: begin
                if (l2_ready) begin
                    state_d   = StResp;
                    d_rdata_d = l2_rdata;
                end
            end
            // Requests are deliberately ignored here so a requester that drops req
            // only after seeing ready is not served twice.
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StIdle;
            owner_q   <= REQ_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign l2_req   = (state_q == StBusyI) || (state_q == StBusyD);
    assign l2_we    = we_q;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_ready  = (state_q == StResp) && (owner_q == REQ_I);
    assign d_ready  = (state_q == StResp) && (owner_q == REQ_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        l2_req;
    logic        l2_we;
    logic [31:0] l2_addr;
    logic [31:0] l2_wdata;
    logic [31:0] l2_rdata = '0;
    logic        l2_ready = 1'b0;

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (LIM)
    ) u_dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .l2_req   (l2_req),
        .l2_we    (l2_we),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_ready (l2_ready)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Transaction-level model: phase 0 = waiting for a request, 1 = l2 access open,
    // 2 = completion being reported.
    bit          m_valid = 1'b0;
    int          m_phase = 0;
    bit          m_own_d = 1'b0;
    int          m_starve = 0;
    logic [31:0] m_addr = '0;
    bit          m_we = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;

    initial begin
        forever begin
            @(posedge CLOCK);
            if (RESET) begin
                m_valid  = 1'b1;
                m_phase  = 0;
                m_starve = 0;
                m_irdata = '0;
                m_drdata = '0;
            end else if (m_valid) begin
                if (m_phase == 0) begin
                    if (d_req && !(i_req && m_starve == LIM)) begin
                        m_own_d = 1'b1;
                        m_addr  = d_addr;
                        m_we    = d_we;
                        m_wdata = d_wdata;
                        if (i_req && m_starve < LIM) m_starve = m_starve + 1;
                        m_phase = 1;
                    end else if (i_req) begin
                        m_own_d  = 1'b0;
                        m_addr   = i_addr;
                        m_we     = 1'b0;
                        m_starve = 0;
                        m_phase  = 1;
                    end
                end else if (m_phase == 1) begin
                    if (l2_ready) begin
                        if (m_own_d) m_drdata = l2_rdata;
                        else m_irdata = l2_rdata;
                        m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK);
            if (m_valid) begin
                check("m_l2_req", l2_req, m_phase == 1);
                check("m_i_ready", i_ready, m_phase == 2 && !m_own_d);
                check("m_d_ready", d_ready, m_phase == 2 && m_own_d);
                check("m_i_rdata", i_rdata, m_irdata);
                check("m_d_rdata", d_rdata, m_drdata);
                if (m_phase == 1) begin
                    check("m_l2_addr", l2_addr, m_addr);
                    check("m_l2_we", l2_we, m_we);
                    if (m_own_d) check("m_l2_wdata", l2_wdata, m_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK);
    endtask

    initial begin
        logic [5:0] gseq;
        int         ngr;
        bit         prev_req;
        int         pulses;

        // Reset state
        repeat (2) tick();
        check("rst_l2_req", l2_req, 0);
        check("rst_l2_addr", l2_addr, 0);
        check("rst_l2_wdata", l2_wdata, 0);
        check("rst_l2_we", l2_we, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        RESET = 1'b0;
        tick();

        // 1: I-only read, three wait cycles
        i_req = 1'b1; i_addr = 32'h0000_0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t1_l2_req", l2_req, 1);
            check("t1_l2_we", l2_we, 0);
            check("t1_l2_addr", l2_addr, 32'h10);
            if (k == 3) begin
                l2_ready = 1'b1; l2_rdata = 32'h8C01_0004;
            end
            tick();
        end
        l2_ready = 1'b0;
        check("t1_i_ready", i_ready, 1);
        check("t1_d_ready", d_ready, 0);
        check("t1_l2_req_low", l2_req, 0);
        check("t1_i_rdata", i_rdata, 32'h8C01_0004);
        i_req = 1'b0;
        tick();
        check("t1_i_ready_once", i_ready, 0);

        // 2: D write, zero-wait l2
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0008_0000; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("t2_l2_req", l2_req, 1);
        check("t2_l2_we", l2_we, 1);
        check("t2_l2_addr", l2_addr, 32'h0008_0000);
        check("t2_l2_wdata", l2_wdata, 32'hDEAD_BEEF);
        l2_ready = 1'b1; l2_rdata = 32'h5555_AAAA;
        tick();
        l2_ready = 1'b0;
        check("t2_d_ready", d_ready, 1);
        check("t2_i_ready", i_ready, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("t2_d_ready_once", d_ready, 0);

        // 3: simultaneous requests from reset
        RESET = 1'b1; tick(); RESET = 1'b0;
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
        tick();
        check("t3_first_d", l2_addr, 32'h200);
        check("t3_starve1", u_dut.starve_cnt, 1);
        l2_ready = 1'b1;
        tick();
        l2_ready = 1'b0;
        check("t3_d_ready", d_ready, 1);
        d_req = 1'b0;
        tick();
        check("t3_idle", l2_req, 0);
        tick();
        check("t3_then_i", l2_addr, 32'h100);
        check("t3_i_we", l2_we, 0);
        check("t3_starve0", u_dut.starve_cnt, 0);
        l2_ready = 1'b1;
        tick();
        l2_ready = 1'b0;
        check("t3_i_ready", i_ready, 1);
        i_req = 1'b0;
        tick();

        // 4: starvation with D requesting continuously
        RESET = 1'b1; tick(); RESET = 1'b0;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = 32'h1234_5678;
        l2_ready = 1'b1;
        gseq = '0; ngr = 0; prev_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (l2_req && !prev_req && ngr < 6) begin
                gseq = {gseq[4:0], l2_we};
                ngr++;
            end
            if (i_ready) i_req = 1'b0;
            prev_req = l2_req;
        end
        check("t4_grant_seq", gseq, 6'b111101);
        d_req = 1'b0; d_we = 1'b0; l2_ready = 1'b0;
        repeat (3) tick();

        // 5: reset mid-BUSY_D
        RESET = 1'b1; tick(); RESET = 1'b0;
        d_req = 1'b1; d_addr = 32'h300;
        tick();
        check("t5_busy", l2_req, 1);
        tick();
        check("t5_busy_hold", l2_req, 1);
        RESET = 1'b1;
        tick();
        check("t5_rst_l2_req", l2_req, 0);
        check("t5_rst_d_ready", d_ready, 0);
        check("t5_rst_state", u_dut.state_q, 0);
        RESET = 1'b0; d_req = 1'b0;
        tick();
        check("t5_no_d_ready", d_ready, 0);
        i_req = 1'b1; i_addr = 32'h400;
        tick();
        check("t5_i_addr", l2_addr, 32'h400);
        l2_ready = 1'b1; l2_rdata = 32'h1234_5678;
        tick();
        l2_ready = 1'b0;
        check("t5_i_ready", i_ready, 1);
        check("t5_i_rdata", i_rdata, 32'h1234_5678);
        i_req = 1'b0;
        tick();

        // 6: spurious l2_ready in idle, requester drops right after ready
        l2_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_idle_l2_req", l2_req, 0);
            check("t6_idle_ready", {i_ready, d_ready}, 0);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (d_ready) begin
                pulses++;
                d_req = 1'b0;
            end
        end
        check("t6_one_pulse", pulses, 1);
        check("t6_end_l2_req", l2_req, 0);
        check("t6_end_state", u_dut.state_q, 0);
        l2_ready = 1'b0;
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if (m_phase == 2 && !m_own_d) i_req = 1'b0;
            if (m_phase == 2 && m_own_d) d_req = 1'b0;
            if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end else if (i_req && !(m_phase != 0 && !m_own_d) && $urandom_range(7) == 0) begin
                i_addr = $urandom;
            end
            if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(1);
            end else if (d_req && !(m_phase != 0 && m_own_d) && $urandom_range(7) == 0) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(1);
            end
            l2_ready = ($urandom_range(2) == 0);
            l2_rdata = $urandom;
            RESET    = ($urandom_range(499) == 0);
            tick();
        end
        RESET = 1'b0; i_req = 1'b0; d_req = 1'b0; l2_ready = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
